// File: rtl/deadlock_proc_monitor.sv
// deadlock_proc_monitor: per-process stall filter, deadlock candidate
// flag and token forwarder feeding the deadlock report unit.
//
// Ports:
//   dl_clock, dl_reset   clock, synchronous active-high reset
//   proc_blocked         raw stall of the monitored process
//   proc_dep_vec         processes this one waits on (bit MY_ID ignored)
//   dep_blocked_vec      blocked_out of every monitor
//   blocked_out          filtered stall flag
//   dl_detect_in         report unit phase: 0 detect, 1 report
//   origin               report unit origin pulse, one bit per process
//   token_in             token addressed to this process
//   token_clear          report unit cycle-complete pulse
//   token_out_vec        one-hot token to the next hop
//   dl_detect_out        candidate / trace bit to the report unit
module deadlock_proc_monitor #(
  parameter int PROC_NUM     = 4,
  parameter int MY_ID        = 0,
  parameter int BLOCK_THRESH = 16
) (
  input  logic                dl_clock,
  input  logic                dl_reset,
  input  logic                proc_blocked,
  input  logic [PROC_NUM-1:0] proc_dep_vec,
  input  logic [PROC_NUM-1:0] dep_blocked_vec,
  output logic                blocked_out,
  input  logic                dl_detect_in,
  input  logic [PROC_NUM-1:0] origin,
  input  logic                token_in,
  input  logic                token_clear,
  output logic [PROC_NUM-1:0] token_out_vec,
  output logic                dl_detect_out
);

  localparam logic [15:0] THRESH = 16'(BLOCK_THRESH);
  localparam logic [PROC_NUM-1:0] SELF =
    PROC_NUM'(1) << MY_ID;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CAND,
    ST_SEND,
    ST_HOLD,
    ST_PASSED
  } state_t;

  state_t              state_q;
  state_t              state_d;
  logic [15:0]         stall_cnt;
  logic                is_origin;
  logic                orig_d;
  logic                det_d;
  logic [PROC_NUM-1:0] tok_d;
  logic [PROC_NUM-1:0] dep;
  logic [PROC_NUM-1:0] hop;
  logic                cand;
  logic                my_origin;
  logic                origin_unused;

  // Only our own origin bit matters.
  assign my_origin     = origin[MY_ID];
  assign origin_unused = ^(origin & ~SELF);

  // Saturating stall filter; any unblocked cycle restarts it.
  always_ff @(posedge dl_clock) begin
    if (dl_reset) begin
      stall_cnt <= '0;
    end else if (!proc_blocked) begin
      stall_cnt <= '0;
    end else if (stall_cnt != THRESH) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end

  assign blocked_out = (stall_cnt == THRESH);

  // A self-dependence cannot close a cycle through us.
  assign dep  = proc_dep_vec & ~SELF;
  assign cand = blocked_out && (|dep) &&
                ~|(dep & ~dep_blocked_vec);

  // Lowest-index dependency is the next hop.
  always_comb begin
    hop = '0;
    for (int i = PROC_NUM - 1; i >= 0; i--) begin
      if (dep[i]) begin
        hop = PROC_NUM'(1) << i;
      end
    end
  end

  always_ff @(posedge dl_clock) begin
    if (dl_reset) begin
      state_q       <= ST_IDLE;
      is_origin     <= 1'b0;
      dl_detect_out <= 1'b0;
      token_out_vec <= '0;
    end else begin
      state_q       <= state_d;
      is_origin     <= orig_d;
      dl_detect_out <= det_d;
      token_out_vec <= tok_d;
    end
  end

  // Outputs are computed for the state being entered so that
  // every pulse appears exactly one cycle after its cause.
  always_comb begin
    state_d = state_q;
    orig_d  = is_origin;
    det_d   = 1'b0;
    tok_d   = '0;
    if (!dl_detect_in) begin
      state_d = cand ? ST_CAND : ST_IDLE;
      orig_d  = 1'b0;
      det_d   = cand;
    end else if (token_clear) begin
      state_d = cand ? ST_CAND : ST_IDLE;
      orig_d  = 1'b0;
    end else if (my_origin &&
                 (state_q == ST_CAND ||
                  state_q == ST_PASSED)) begin
      state_d = ST_SEND;
      orig_d  = 1'b1;
      tok_d   = hop;
    end else if (token_in &&
                 state_q != ST_SEND &&
                 state_q != ST_HOLD) begin
      // The origin swallows its returning token.
      state_d = ST_HOLD;
      det_d   = 1'b1;
      tok_d   = is_origin ? '0 : hop;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (cand) begin
            state_d = ST_CAND;
          end
        end
        ST_SEND,
        ST_HOLD: begin
          state_d = ST_PASSED;
        end
        default: begin
          state_d = state_q;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_deadlock_proc_monitor.sv
// tb_deadlock_proc_monitor: directed and randomized checks of the
// per-process deadlock monitor against a behavioural model.
module tb_deadlock_proc_monitor;

  localparam int N  = 4;
  localparam int ID = 0;
  localparam int T  = 4;

  logic         clk = 1'b0;
  logic         dl_reset = 1'b1;
  logic         proc_blocked = 1'b0;
  logic [N-1:0] proc_dep_vec = '0;
  logic [N-1:0] dep_blocked_vec = '0;
  logic         blocked_out;
  logic         dl_detect_in = 1'b0;
  logic [N-1:0] origin = '0;
  logic         token_in = 1'b0;
  logic         token_clear = 1'b0;
  logic [N-1:0] token_out_vec;
  logic         dl_detect_out;

  always #5 clk = ~clk;

  deadlock_proc_monitor #(
    .PROC_NUM(N),
    .MY_ID(ID),
    .BLOCK_THRESH(T)
  ) dut (
    .dl_clock(clk),
    .dl_reset(dl_reset),
    .proc_blocked(proc_blocked),
    .proc_dep_vec(proc_dep_vec),
    .dep_blocked_vec(dep_blocked_vec),
    .blocked_out(blocked_out),
    .dl_detect_in(dl_detect_in),
    .origin(origin),
    .token_in(token_in),
    .token_clear(token_clear),
    .token_out_vec(token_out_vec),
    .dl_detect_out(dl_detect_out)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(string name, logic [31:0] act,
                     logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h",
               name, act, exp);
    end
  endtask

  // Behavioural model. run = length of the current run of
  // stalled cycles; role: 0 idle, 1 armed, 2 one-cycle hop
  // (send or hold), 3 passed.
  int           run = 0;
  int           role = 0;
  bit           m_orig = 1'b0;
  bit           e_blk = 1'b0;
  bit           e_det = 1'b0;
  bit [N-1:0]   e_tok = '0;
  bit           started = 1'b0;

  always @(posedge clk) begin : model
    bit [N-1:0] d;
    bit [N-1:0] nh;
    bit         blk;
    bit         c;
    blk = (run >= T);
    d = proc_dep_vec;
    d[ID] = 1'b0;
    nh = d & (~d + N'(1));
    c = blk && (d != 0) && ((d & ~dep_blocked_vec) == 0);
    e_det = 1'b0;
    e_tok = '0;
    if (dl_reset) begin
      run = 0;
      role = 0;
      m_orig = 1'b0;
      started = 1'b1;
    end else begin
      run = proc_blocked ? run + 1 : 0;
      if (!dl_detect_in) begin
        role = c ? 1 : 0;
        m_orig = 1'b0;
        e_det = c;
      end else if (token_clear) begin
        role = c ? 1 : 0;
        m_orig = 1'b0;
      end else if (origin[ID] && (role == 1 || role == 3)) begin
        role = 2;
        m_orig = 1'b1;
        e_tok = nh;
      end else if (token_in && role != 2) begin
        role = 2;
        e_det = 1'b1;
        e_tok = m_orig ? '0 : nh;
      end else if (role == 2) begin
        role = 3;
      end else if (role == 0 && c) begin
        role = 1;
      end
    end
    e_blk = (run >= T);
  end

  always @(negedge clk) begin
    if (started) begin
      chk("blocked_out", 32'(blocked_out), 32'(e_blk));
      chk("dl_detect_out", 32'(dl_detect_out), 32'(e_det));
      chk("token_out_vec", 32'(token_out_vec), 32'(e_tok));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    cyc();
    cyc();
    chk("rst_blocked", 32'(blocked_out), 32'd0);
    chk("rst_det", 32'(dl_detect_out), 32'd0);
    chk("rst_tok", 32'(token_out_vec), 32'd0);
    dl_reset = 1'b0;

    // stall filter
    proc_blocked = 1'b1;
    repeat (3) cyc();
    chk("filt_c3", 32'(blocked_out), 32'd0);
    cyc();
    chk("filt_c4", 32'(blocked_out), 32'd1);
    proc_blocked = 1'b0;
    cyc();
    chk("filt_fall", 32'(blocked_out), 32'd0);
    proc_blocked = 1'b1;
    cyc();
    cyc();
    proc_blocked = 1'b0;
    cyc();
    proc_blocked = 1'b1;
    repeat (3) cyc();
    chk("glitch_c6", 32'(blocked_out), 32'd0);
    cyc();
    chk("glitch_c7", 32'(blocked_out), 32'd1);

    // candidate
    proc_dep_vec = 4'b0010;
    cyc();
    chk("cand_dep_free", 32'(dl_detect_out), 32'd0);
    dep_blocked_vec = 4'b0010;
    cyc();
    chk("cand_set", 32'(dl_detect_out), 32'd1);
    proc_blocked = 1'b0;
    cyc();
    cyc();
    chk("cand_drop", 32'(dl_detect_out), 32'd0);

    // origin
    proc_blocked = 1'b1;
    repeat (5) cyc();
    chk("cand_again", 32'(dl_detect_out), 32'd1);
    dl_detect_in = 1'b1;
    origin = 4'b0001;
    cyc();
    chk("org_tok", 32'(token_out_vec), 32'h2);
    chk("org_det", 32'(dl_detect_out), 32'd0);
    origin = '0;
    cyc();
    chk("org_passed", 32'(token_out_vec), 32'd0);
    cyc();
    token_in = 1'b1;
    cyc();
    chk("org_ret_det", 32'(dl_detect_out), 32'd1);
    chk("org_ret_tok", 32'(token_out_vec), 32'd0);
    token_in = 1'b0;
    cyc();
    chk("org_after", 32'(dl_detect_out), 32'd0);
    token_clear = 1'b1;
    cyc();
    token_clear = 1'b0;

    // forwarding, bit 0 is self and masked
    proc_dep_vec = 4'b1101;
    dep_blocked_vec = 4'b1100;
    token_in = 1'b1;
    cyc();
    chk("fwd_det", 32'(dl_detect_out), 32'd1);
    chk("fwd_tok", 32'(token_out_vec), 32'h4);
    token_in = 1'b0;
    cyc();
    chk("fwd_end_det", 32'(dl_detect_out), 32'd0);
    chk("fwd_end_tok", 32'(token_out_vec), 32'd0);

    // priority
    token_clear = 1'b1;
    token_in = 1'b1;
    cyc();
    chk("pri_clr_tok", 32'(token_out_vec), 32'd0);
    chk("pri_clr_det", 32'(dl_detect_out), 32'd0);
    token_clear = 1'b0;
    origin = 4'b0001;
    cyc();
    chk("pri_org_tok", 32'(token_out_vec), 32'h4);
    chk("pri_org_det", 32'(dl_detect_out), 32'd0);
    origin = '0;
    token_in = 1'b0;
    cyc();
    token_clear = 1'b1;
    cyc();
    token_clear = 1'b0;

    // reset during hold
    token_in = 1'b1;
    cyc();
    chk("hold_det", 32'(dl_detect_out), 32'd1);
    chk("hold_tok", 32'(token_out_vec), 32'h4);
    token_in = 1'b0;
    dl_reset = 1'b1;
    cyc();
    chk("rh_blk", 32'(blocked_out), 32'd0);
    chk("rh_det", 32'(dl_detect_out), 32'd0);
    chk("rh_tok", 32'(token_out_vec), 32'd0);
    dl_reset = 1'b0;
    repeat (3) cyc();
    chk("refilt_c3", 32'(blocked_out), 32'd0);
    cyc();
    chk("refilt_c4", 32'(blocked_out), 32'd1);
    dl_detect_in = 1'b0;
    cyc();

    // randomized
    for (int i = 0; i < 4000; i++) begin
      dl_reset = ($urandom_range(0, 299) == 0);
      proc_blocked = ($urandom_range(0, 19) != 0);
      if ($urandom_range(0, 15) == 0)
        proc_dep_vec = 4'($urandom);
      if ($urandom_range(0, 3) != 0)
        dep_blocked_vec = proc_dep_vec | 4'($urandom);
      else
        dep_blocked_vec = 4'($urandom);
      if ($urandom_range(0, 39) == 0)
        dl_detect_in = ~dl_detect_in;
      origin = ($urandom_range(0, 7) == 0) ? 4'($urandom) : '0;
      token_in = ($urandom_range(0, 4) == 0);
      token_clear = ($urandom_range(0, 19) == 0);
      cyc();
    end
    dl_reset = 1'b0;
    token_in = 1'b0;
    token_clear = 1'b0;
    origin = '0;
    repeat (3) cyc();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
